// File: rtl/sprite_pkg.sv
// Shared sprite constants and ROM bank selector for the sprite renderer.
package sprite_pkg;

    localparam int unsigned SPRITE_SIZE  = 16;
    localparam int unsigned SPRITE_IDX_W = $clog2(SPRITE_SIZE);

    typedef enum logic [1:0] {
        SPR_GHOST      = 2'd0,
        SPR_PAC_OPEN   = 2'd1,
        SPR_PAC_CLOSED = 2'd2
    } sprite_sel_t;

    localparam logic [2:0] SPRITE_ID_PAC = 3'd0;

endpackage

// File: rtl/sprite_hit.sv
// Combinational hit test of one 16x16 sprite against the current pixel.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int unsigned COORD_W = 10
) (
    input  logic [COORD_W-1:0]      i_draw_x,
    input  logic [COORD_W-1:0]      i_draw_y,
    input  logic [COORD_W-1:0]      i_pos_x,
    input  logic [COORD_W-1:0]      i_pos_y,
    input  logic                    i_valid,
    output logic [SPRITE_IDX_W-1:0] o_dx_c,
    output logic [SPRITE_IDX_W-1:0] o_dy_c,
    output logic                    o_hit_c
);

    logic [COORD_W:0] w_dx;
    logic [COORD_W:0] w_dy;

    // One extra bit keeps the sign, so pixels left/above the sprite never alias.
    assign w_dx = {1'b0, i_draw_x} - {1'b0, i_pos_x};
    assign w_dy = {1'b0, i_draw_y} - {1'b0, i_pos_y};

    assign o_hit_c = i_valid
                   & (w_dx[COORD_W:SPRITE_IDX_W] == '0)
                   & (w_dy[COORD_W:SPRITE_IDX_W] == '0);
    assign o_dx_c  = w_dx[SPRITE_IDX_W-1:0];
    assign o_dy_c  = w_dy[SPRITE_IDX_W-1:0];

endmodule

// File: rtl/sprite_renderer.sv
// Per-pixel Pac-Man/ghost renderer: frame-latched positions, priority pick,
// two-stage ROM lookup pipeline and mouth animation.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS  = 4,
    parameter int unsigned ANIM_FRAMES = 8,
    parameter int unsigned COORD_W     = 10
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          frame_start,
    input  logic [COORD_W-1:0]            DrawX,
    input  logic [COORD_W-1:0]            DrawY,
    input  logic [COORD_W-1:0]            pac_x,
    input  logic [COORD_W-1:0]            pac_y,
    input  logic                          pac_face_left,
    input  logic                          pac_moving,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
    output logic [5:0]                    rom_addr,
    input  logic [15:0]                   rom_data,
    output logic                          sprite_on,
    output logic [2:0]                    sprite_id
);

    localparam int unsigned NSPR  = NUM_GHOSTS + 1;
    localparam int unsigned CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic [COORD_W-1:0]      w_in_x  [NSPR];
    logic [COORD_W-1:0]      w_in_y  [NSPR];
    logic [COORD_W-1:0]      r_pos_x [NSPR];
    logic [COORD_W-1:0]      r_pos_y [NSPR];
    logic                    r_pos_valid;
    logic                    r_face_left;
    logic                    r_mouth_open;
    logic [CNT_W-1:0]        r_anim_cnt;

    logic [SPRITE_IDX_W-1:0] w_dx    [NSPR];
    logic [SPRITE_IDX_W-1:0] w_dy    [NSPR];
    logic [NSPR-1:0]         w_hit;

    sprite_sel_t             w_sel;
    logic [SPRITE_IDX_W-1:0] w_row;
    logic [SPRITE_IDX_W-1:0] w_col;
    logic                    w_mirror;
    logic                    w_hit_any;
    logic [2:0]              w_id;

    logic [5:0]              r_rom_addr;
    logic [SPRITE_IDX_W-1:0] r_col;
    logic                    r_mirror;
    logic                    r_hit_any;
    logic [2:0]              r_id;

    logic [SPRITE_IDX_W-1:0] w_bit;
    logic                    w_on_c;
    logic                    r_sprite_on;
    logic [2:0]              r_sprite_id;

    assign w_in_x[0] = pac_x;
    assign w_in_y[0] = pac_y;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost_in
        assign w_in_x[g+1] = ghost_x[g*COORD_W +: COORD_W];
        assign w_in_y[g+1] = ghost_y[g*COORD_W +: COORD_W];
    end

    // Shadow positions only change at frame start so sprites never tear mid-frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pos_x     <= '{default: '0};
            r_pos_y     <= '{default: '0};
            r_pos_valid <= 1'b0;
            r_face_left <= 1'b0;
        end else if (frame_start) begin
            r_pos_x     <= w_in_x;
            r_pos_y     <= w_in_y;
            r_pos_valid <= 1'b1;
            r_face_left <= pac_face_left;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_anim_cnt   <= '0;
            r_mouth_open <= 1'b1;
        end else if (frame_start && pac_moving) begin
            if (r_anim_cnt == CNT_W'(ANIM_FRAMES - 1)) begin
                r_anim_cnt   <= '0;
                r_mouth_open <= ~r_mouth_open;
            end else begin
                r_anim_cnt   <= r_anim_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NSPR; g++) begin : g_hit
        sprite_hit #(
            .COORD_W (COORD_W)
        ) u_hit (
            .i_draw_x (DrawX),
            .i_draw_y (DrawY),
            .i_pos_x  (r_pos_x[g]),
            .i_pos_y  (r_pos_y[g]),
            .i_valid  (r_pos_valid),
            .o_dx_c   (w_dx[g]),
            .o_dy_c   (w_dy[g]),
            .o_hit_c  (w_hit[g])
        );
    end

    // Walk from lowest to highest priority so Pac-Man overrides every ghost.
    always_comb begin
        w_sel     = SPR_GHOST;
        w_row     = '0;
        w_col     = '0;
        w_mirror  = 1'b0;
        w_hit_any = 1'b0;
        w_id      = SPRITE_ID_PAC;
        for (int i = int'(NUM_GHOSTS); i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_any = 1'b1;
                w_id      = 3'(i);
                w_row     = w_dy[i];
                w_col     = w_dx[i];
                w_mirror  = (i == 0) && r_face_left;
                if (i == 0) begin
                    w_sel = r_mouth_open ? SPR_PAC_OPEN : SPR_PAC_CLOSED;
                end else begin
                    w_sel = SPR_GHOST;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_col      <= '0;
            r_mirror   <= 1'b0;
            r_hit_any  <= 1'b0;
            r_id       <= '0;
        end else begin
            r_rom_addr <= {w_sel, w_row};
            r_col      <= w_col;
            r_mirror   <= w_mirror;
            r_hit_any  <= w_hit_any;
            r_id       <= w_id;
        end
    end

    // ROM rows store the leftmost column in bit 15.
    assign w_bit  = r_mirror ? r_col : SPRITE_IDX_W'(SPRITE_SIZE - 1) - r_col;
    assign w_on_c = r_hit_any & rom_data[w_bit];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sprite_on <= 1'b0;
            r_sprite_id <= '0;
        end else begin
            r_sprite_on <= w_on_c;
            r_sprite_id <= w_on_c ? r_id : 3'd0;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign sprite_on = r_sprite_on;
    assign sprite_id = r_sprite_id;

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomized bench for sprite_renderer against a rectangle-overlap reference model.
module tb_sprite_renderer;

    localparam int unsigned NG = 4;
    localparam int unsigned AF = 2;
    localparam int unsigned CW = 10;

    logic             Clk;
    logic             Reset_n;
    logic             frame_start;
    logic [CW-1:0]    DrawX;
    logic [CW-1:0]    DrawY;
    logic [CW-1:0]    pac_x;
    logic [CW-1:0]    pac_y;
    logic             pac_face_left;
    logic             pac_moving;
    logic [NG*CW-1:0] ghost_x;
    logic [NG*CW-1:0] ghost_y;
    logic [5:0]       rom_addr;
    logic [15:0]      rom_data;
    logic             sprite_on;
    logic [2:0]       sprite_id;

    logic [15:0]      rom [64];

    typedef struct {
        int addr;
        int on;
        int id;
    } exp_t;

    int   n_vec;
    int   n_err;
    int   gx [NG];
    int   gy [NG];
    int   m_x [NG+1];
    int   m_y [NG+1];
    bit   m_valid;
    bit   m_face;
    int   m_moves;
    exp_t prev_e;

    sprite_renderer #(
        .NUM_GHOSTS  (NG),
        .ANIM_FRAMES (AF),
        .COORD_W     (CW)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_start   (frame_start),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .pac_x         (pac_x),
        .pac_y         (pac_y),
        .pac_face_left (pac_face_left),
        .pac_moving    (pac_moving),
        .ghost_x       (ghost_x),
        .ghost_y       (ghost_y),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sprite_on     (sprite_on),
        .sprite_id     (sprite_id)
    );

    assign rom_data = rom[rom_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_open();
        return ((m_moves / int'(AF)) % 2) == 0;
    endfunction

    // First sprite in priority order whose 16x16 box contains the pixel decides everything.
    function automatic exp_t lookup(input int x, input int y);
        exp_t e;
        e.addr = 0;
        e.on   = 0;
        e.id   = 0;
        if (!m_valid) return e;
        for (int s = 0; s <= int'(NG); s++) begin
            if (x >= m_x[s] && x < m_x[s] + 16 && y >= m_y[s] && y < m_y[s] + 16) begin
                int sel;
                int c;
                int b;
                sel    = (s == 0) ? (m_open() ? 1 : 2) : 0;
                c      = x - m_x[s];
                b      = (s == 0 && m_face) ? c : 15 - c;
                e.addr = sel * 16 + (y - m_y[s]);
                e.on   = int'(rom[e.addr][b]);
                e.id   = (e.on != 0) ? s : 0;
                return e;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_face   = 1'b0;
        m_moves  = 0;
        for (int s = 0; s <= int'(NG); s++) begin
            m_x[s] = 0;
            m_y[s] = 0;
        end
        prev_e.addr = 0;
        prev_e.on   = 0;
        prev_e.id   = 0;
    endtask

    task automatic model_latch();
        m_x[0] = int'(pac_x);
        m_y[0] = int'(pac_y);
        for (int i = 0; i < int'(NG); i++) begin
            m_x[i+1] = int'(ghost_x[i*CW +: CW]);
            m_y[i+1] = int'(ghost_y[i*CW +: CW]);
        end
        m_face  = pac_face_left;
        m_valid = 1'b1;
        if (pac_moving) m_moves++;
    endtask

    task automatic set_sprites(input int px, input int py);
        pac_x = CW'(px);
        pac_y = CW'(py);
        for (int i = 0; i < int'(NG); i++) begin
            ghost_x[i*CW +: CW] = CW'(gx[i]);
            ghost_y[i*CW +: CW] = CW'(gy[i]);
        end
    endtask

    // One pixel clock: drive, clock, update model, then compare both pipeline stages.
    task automatic step(input bit fs, input int x, input int y);
        exp_t cur;
        frame_start = fs;
        DrawX       = CW'(x);
        DrawY       = CW'(y);
        cur         = lookup(x, y);
        @(posedge Clk);
        if (fs) model_latch();
        #1;
        chk("rom_addr", int'(rom_addr), cur.addr);
        chk("sprite_on", int'(sprite_on), prev_e.on);
        chk("sprite_id", int'(sprite_id), prev_e.id);
        prev_e = cur;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_sprite_on", int'(sprite_on), 0);
        chk("rst_sprite_id", int'(sprite_id), 0);
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic randomize_pos();
        int bx;
        int by;
        bx = int'($urandom_range(0, 1023));
        by = int'($urandom_range(0, 1023));
        for (int i = 0; i < int'(NG); i++) begin
            gx[i] = (bx + int'($urandom_range(0, 24))) & 1023;
            gy[i] = (by + int'($urandom_range(0, 24))) & 1023;
        end
        set_sprites((bx + int'($urandom_range(0, 24))) & 1023,
                    (by + int'($urandom_range(0, 24))) & 1023);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int a = 0; a < 64; a++) rom[a] = 16'($urandom);
        Reset_n       = 1'b0;
        frame_start   = 1'b0;
        DrawX         = '0;
        DrawY         = '0;
        pac_face_left = 1'b0;
        pac_moving    = 1'b0;
        for (int i = 0; i < int'(NG); i++) begin
            gx[i] = 0;
            gy[i] = 0;
        end
        set_sprites(0, 0);
        model_reset();

        #12;
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_sprite_on", int'(sprite_on), 0);
        chk("reset_sprite_id", int'(sprite_id), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Nothing may be drawn before the first frame_start, even on top of (0,0).
        for (int i = 0; i < 8; i++) step(1'b0, i, i);

        for (int i = 0; i < int'(NG); i++) begin
            gx[i] = 500 + 40 * i;
            gy[i] = 400;
        end
        set_sprites(100, 50);
        step(1'b1, 0, 0);
        step(1'b0, 108, 54);
        step(1'b0, 101, 54);
        step(1'b0, 101, 54);

        gx[0] = 200; gy[0] = 200;
        gx[1] = 205; gy[1] = 200;
        set_sprites(100, 50);
        step(1'b1, 0, 0);
        step(1'b0, 206, 203);
        step(1'b0, 210, 203);
        step(1'b0, 210, 203);

        pac_face_left = 1'b1;
        set_sprites(0, 0);
        step(1'b1, 0, 0);
        step(1'b0, 15, 7);
        pac_face_left = 1'b0;
        step(1'b1, 0, 0);
        step(1'b0, 15, 7);
        step(1'b0, 15, 7);

        pac_moving = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 3, 3);
            step(1'b0, 3, 3);
        end
        pac_moving = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3, 3);
            step(1'b0, 3, 3);
        end

        set_sprites(630, 100);
        step(1'b1, 0, 0);
        step(1'b0, 639, 105);
        step(1'b0, 629, 105);
        step(1'b0, 645, 105);
        set_sprites(632, 100);
        step(1'b1, 631, 105);
        step(1'b0, 631, 105);
        step(1'b0, 640, 105);

        set_sprites(1015, 1012);
        step(1'b1, 0, 0);
        step(1'b0, 1023, 1023);
        step(1'b0, 3, 1015);
        step(1'b0, 3, 1015);

        for (int n = 0; n < 3000; n++) begin
            int  x;
            int  y;
            int  s;
            bit  fs;
            if (n == 1500) do_reset();
            if ($urandom_range(0, 49) == 0) randomize_pos();
            if ($urandom_range(0, 9) == 0) pac_moving = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) pac_face_left = 1'($urandom_range(0, 1));
            fs = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end else begin
                s = int'($urandom_range(0, NG));
                x = (m_x[s] + int'($urandom_range(0, 19)) - 2) & 1023;
                y = (m_y[s] + int'($urandom_range(0, 19)) - 2) & 1023;
            end
            step(fs, x, y);
        end
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
